// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its companion detectors.
// Holds the FSM state encoding and the default pattern constants.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [7:0] PAT_ONES8 = 8'hFF;
  localparam logic [7:0] PAT_B4    = 8'hB4;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control and serial-output bundle of the pattern generator.
// The master side requests bursts; the slave side (the generator) drives the serial line.
interface seq_pattern_gen_if #(
  parameter int RPT_W = 4
);

  logic             start;
  logic [RPT_W-1:0] rpt_n;
  logic             abort;
  logic             p;
  logic             p_valid;
  logic             last_bit;
  logic             busy;
  logic             done;

  modport master (
    output start, rpt_n, abort,
    input  p, p_valid, last_bit, busy, done
  );

  modport slave (
    input  start, rpt_n, abort,
    output p, p_valid, last_bit, busy, done
  );

endinterface

// File: rtl/seq_shift_out.sv
// Loadable MSB-first shift register with a bit counter and a registered last-bit flag.
// Zeros shift in behind the pattern, so the serial output drops to 0 once the pattern has gone.
module seq_shift_out #(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] PATTERN = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic clear,
  output logic bit_out,
  output logic last
);

  localparam int CNT_W = $clog2(PAT_W);

  logic [PAT_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             last_q, last_d;

  always_comb begin
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    if (clear) begin
      sreg_d    = '0;
      bit_cnt_d = '0;
      last_d    = 1'b0;
    end else if (load) begin
      sreg_d    = PATTERN;
      bit_cnt_d = '0;
      last_d    = 1'b0;
    end else if (shift) begin
      sreg_d    = {sreg_q[PAT_W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      // Flag goes high together with the bit that is about to be presented last.
      last_d    = (bit_cnt_q == CNT_W'(PAT_W - 2));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
    end else begin
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
    end
  end

  assign bit_out = sreg_q[PAT_W-1];
  assign last    = last_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN MSB first followed by a zero gap, repeated
// rpt_n times (0 = until aborted). All outputs come straight from flops.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] PATTERN = PAT_ONES8,
  parameter int               GAP_W   = 2,
  parameter int               RPT_W   = 4
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_gen_if.slave bus
);

  localparam int GAP_CW = (GAP_W > 1) ? $clog2(GAP_W) : 1;

  state_t            state_q, state_d;
  logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
  logic [RPT_W-1:0]  rpt_left_q, rpt_left_d;
  logic              abort_pend_q, abort_pend_d;
  logic              p_valid_q, p_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic sh_load, sh_shift, sh_clear, sh_bit, sh_last;
  logic boundary;

  seq_shift_out #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .shift   (sh_shift),
    .clear   (sh_clear),
    .bit_out (sh_bit),
    .last    (sh_last)
  );

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    rpt_left_d   = rpt_left_q;
    p_valid_d    = p_valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    sh_clear     = 1'b0;
    boundary     = 1'b0;
    abort_pend_d = abort_pend_q | (bus.abort && (state_q == SEND || state_q == GAP));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = SEND;
          sh_load      = 1'b1;
          rpt_left_d   = bus.rpt_n;
          p_valid_d    = 1'b1;
          busy_d       = 1'b1;
          abort_pend_d = 1'b0;
        end
      end
      SEND: begin
        if (sh_last) begin
          if (GAP_W == 0) begin
            boundary = 1'b1;
          end else begin
            state_d   = GAP;
            sh_shift  = 1'b1;
            gap_cnt_d = '0;
          end
        end else begin
          sh_shift = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_CW'(GAP_W - 1)) begin
          boundary = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_CW'(1);
        end
      end
      FIN: begin
        state_d      = IDLE;
        done_d       = 1'b0;
        busy_d       = 1'b0;
        abort_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // A repeat count of 0 never decrements, so continuous mode only ends through abort.
    if (boundary) begin
      if (rpt_left_q != '0) begin
        rpt_left_d = rpt_left_q - RPT_W'(1);
      end
      if (abort_pend_d || rpt_left_q == RPT_W'(1)) begin
        state_d   = FIN;
        sh_clear  = 1'b1;
        p_valid_d = 1'b0;
        done_d    = 1'b1;
      end else begin
        state_d = SEND;
        sh_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      rpt_left_q   <= '0;
      abort_pend_q <= 1'b0;
      p_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      rpt_left_q   <= rpt_left_d;
      abort_pend_q <= abort_pend_d;
      p_valid_q    <= p_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.p        = sh_bit;
  assign bus.last_bit = sh_last;
  assign bus.p_valid  = p_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: per-cycle expected output words are queued as
// stimulus is driven and compared on the falling edge.
module tb_seq_pattern_gen;

  typedef logic [4:0] exp_t;  // {p, p_valid, last_bit, busy, done}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_pattern_gen_if #(.RPT_W(4)) b0 ();
  seq_pattern_gen_if #(.RPT_W(4)) b1 ();
  seq_pattern_gen_if #(.RPT_W(4)) b2 ();

  seq_pattern_gen #(.PAT_W(8), .PATTERN(8'hFF), .GAP_W(2), .RPT_W(4))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  seq_pattern_gen #(.PAT_W(8), .PATTERN(8'hB4), .GAP_W(0), .RPT_W(4))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  seq_pattern_gen #(.PAT_W(8), .PATTERN(8'hFF), .GAP_W(0), .RPT_W(4))
    dut2 (.clk(clk), .rst(rst), .bus(b2));

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   compareCount  = 0;
  int   mismatchCount = 0;
  int   run2   = 0;
  int   ticks2 = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic pushEntry(input int sel, input exp_t e);
    if (sel == 0) q0.push_back(e);
    else if (sel == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  task automatic pushIdle(input int sel, input int n);
    for (int i = 0; i < n; i++) pushEntry(sel, 5'b00000);
  endtask

  // Reference sequence: patterns with gaps, FIN cycle, then one idle cycle.
  task automatic pushBurst(input int sel, input logic [31:0] pat, input int patW,
                           input int gapW, input int reps, input int abortRep);
    int nReps;
    nReps = (abortRep > 0 && (reps == 0 || abortRep < reps)) ? abortRep : reps;
    for (int r = 0; r < nReps; r++) begin
      for (int b = 0; b < patW; b++)
        pushEntry(sel, {pat[patW-1-b], 1'b1, (b == patW - 1), 1'b1, 1'b0});
      for (int g = 0; g < gapW; g++)
        pushEntry(sel, 5'b01010);
    end
    pushEntry(sel, 5'b00011);
    pushIdle(sel, 1);
  endtask

  task automatic applyStimulus(input int sel, input int rptN);
    if (sel == 0) begin b0.start = 1'b1; b0.rpt_n = 4'(rptN); end
    else if (sel == 1) begin b1.start = 1'b1; b1.rpt_n = 4'(rptN); end
    else begin b2.start = 1'b1; b2.rpt_n = 4'(rptN); end
    @(posedge clk);
    #1;
    b0.start = 1'b0;
    b1.start = 1'b0;
    b2.start = 1'b0;
  endtask

  task automatic waitDrain(input int sel);
    int left;
    left = 0;
    for (int i = 0; i < 500; i++) begin
      left = (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
      if (left == 0) break;
      @(posedge clk);
    end
    checkOutput("drain timeout", left, 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (q0.size() > 0) checkOutput("dut0 {p,pv,lb,busy,done}", {b0.p, b0.p_valid, b0.last_bit, b0.busy, b0.done}, q0.pop_front());

  always @(negedge clk)
    if (q1.size() > 0) checkOutput("dut1 {p,pv,lb,busy,done}", {b1.p, b1.p_valid, b1.last_bit, b1.busy, b1.done}, q1.pop_front());

  // Stand-in for the 8-ones detector: counts cycles where the trailing run of 1s reaches 8.
  always @(negedge clk) begin
    if (q2.size() > 0) checkOutput("dut2 {p,pv,lb,busy,done}", {b2.p, b2.p_valid, b2.last_bit, b2.busy, b2.done}, q2.pop_front());
    if (b2.p && b2.p_valid) run2++;
    else run2 = 0;
    if (run2 >= 8) ticks2++;
  end

  initial begin
    b0.start = 1'b0; b0.rpt_n = '0; b0.abort = 1'b0;
    b1.start = 1'b0; b1.rpt_n = '0; b1.abort = 1'b0;
    b2.start = 1'b0; b2.rpt_n = '0; b2.abort = 1'b0;
    #2;
    checkOutput("reset dut0", {b0.p, b0.p_valid, b0.last_bit, b0.busy, b0.done}, 0);
    checkOutput("reset dut1", {b1.p, b1.p_valid, b1.last_bit, b1.busy, b1.done}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single burst, ones pattern, gap 2");
    pushIdle(0, 1);
    pushBurst(0, 32'hFF, 8, 2, 1, 0);
    applyStimulus(0, 1);
    waitDrain(0);

    $display("[TB] 0xB4 pattern, no gap, three repeats");
    pushIdle(1, 1);
    pushBurst(1, 32'hB4, 8, 0, 3, 0);
    applyStimulus(1, 3);
    waitDrain(1);

    $display("[TB] continuous mode ended by abort in repetition 5");
    pushIdle(0, 1);
    pushBurst(0, 32'hFF, 8, 2, 0, 5);
    applyStimulus(0, 0);
    repeat (41) @(posedge clk);
    #1 b0.abort = 1'b1;
    @(posedge clk);
    #1 b0.abort = 1'b0;
    waitDrain(0);

    $display("[TB] start held high across two bursts");
    pushIdle(0, 1);
    pushBurst(0, 32'hFF, 8, 2, 1, 0);
    pushBurst(0, 32'hFF, 8, 2, 1, 0);
    pushIdle(0, 1);
    b0.start = 1'b1;
    b0.rpt_n = 4'd1;
    repeat (17) @(posedge clk);
    #1 b0.start = 1'b0;
    waitDrain(0);

    $display("[TB] reset during SEND");
    pushIdle(0, 1);
    for (int i = 0; i < 3; i++) pushEntry(0, 5'b11010);
    applyStimulus(0, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    pushIdle(0, 3);
    #1;
    checkOutput("rst mid-send", {b0.p, b0.p_valid, b0.last_bit, b0.busy, b0.done}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    waitDrain(0);

    $display("[TB] burst after reset");
    pushIdle(0, 1);
    pushBurst(0, 32'hFF, 8, 2, 1, 0);
    applyStimulus(0, 1);
    waitDrain(0);

    $display("[TB] ones pattern, no gap, two repeats into run detector");
    pushIdle(2, 1);
    pushBurst(2, 32'hFF, 8, 0, 2, 0);
    applyStimulus(2, 2);
    waitDrain(2);
    checkOutput("ones8 tick cycles", ticks2, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter. It is the source side of the serial bit-sequence detectors in the sequence detector block.
- On command, it drives a fixed, parameterised bit pattern out on a 1-bit serial line, MSB first.
- Each pattern is followed by a zero gap. The pattern plus gap repeats a programmable number of times, or continuously until aborted.
- Used as an on-chip stimulus source for the detectors and as a framing/preamble generator.

Parameters:
- PAT_W, 8: pattern length in bits. Legal range 2..32.
- PATTERN, 8'hFF: pattern value, PAT_W bits. Bit PAT_W-1 is sent first.
- GAP_W, 2: number of forced-0 bit cycles after each pattern. 0 is legal and means patterns are sent back-to-back.
- RPT_W, 4: width of the repeat-count input.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request a burst. Sampled only in IDLE.
- rpt_n, input, RPT_W: number of pattern repetitions, captured with start. 0 means continuous.
- abort, input, 1: stop the burst at the next pattern boundary.
- p, output, 1: serial data out (registered).
- p_valid, output, 1: high while p carries pattern or gap bits.
- last_bit, output, 1: high in the cycle p carries the final bit of a pattern.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: single-cycle pulse when a burst ends.

Behaviour:
- Reset values, applied immediately while rst is high: state=IDLE, p=0, p_valid=0, last_bit=0, busy=0, done=0, all counters 0.
- All outputs are registered. There is no combinational path from input to output.
- States: IDLE, SEND, GAP, FIN.
- IDLE:
  - start=1 at edge k captures rpt_n into rpt_left and the pattern into the shift register.
  - The FSM goes to SEND at edge k.
  - The first pattern bit (PATTERN[PAT_W-1]) appears on p, with p_valid=1, in the cycle after edge k. Latency is 1 clock.
  - start while busy is ignored.
- SEND:
  - Shifts out one bit per clock, MSB first. bit_cnt counts 0..PAT_W-1.
  - last_bit=1 coincides with bit PAT_W-1 on p.
  - After the last bit:
    - if GAP_W>0, go to GAP;
    - if GAP_W=0, apply the boundary decision directly (see below).
- GAP:
  - p=0 and p_valid=1 for exactly GAP_W cycles, counted by gap_cnt.
  - After the gap, apply the boundary decision.
- Boundary decision, taken after each pattern plus gap:
  - Decrement rpt_left if it is nonzero.
  - Go to FIN if:
    - abort has been latched, or
    - rpt_left was 1, i.e. the final repetition has just finished.
  - Otherwise reload the shift register and return to SEND. The next pattern's first bit follows with no idle cycle.
  - rpt_left=0 at capture (continuous mode) never reaches the count-out condition. Only abort ends it.
- abort:
  - Is latched into an abort_pend flag whenever it is high in SEND or GAP.
  - Never truncates a pattern or gap in progress.
  - Is ignored in IDLE and FIN.
  - abort_pend is cleared on entry to IDLE.
- FIN:
  - Lasts one cycle: p=0, p_valid=0, done=1, busy=1.
  - Then goes to IDLE. busy=0 from the following cycle.
- In IDLE, p=0 and p_valid=0.
- A start in the cycle after FIN is accepted. Minimum spacing between bursts is one idle cycle.
- Reset mid-burst aborts immediately. No done pulse is produced.
- Simultaneous abort and final-repetition boundary: go to FIN once, with a single done pulse.

Decomposition:
- Shared package seq_pkg holds:
  - the state encoding constants IDLE=2'd0, SEND=2'd1, GAP=2'd2, FIN=2'd3;
  - default pattern constants shared with the detectors (e.g. PAT_ONES8=8'hFF).
- One natural sub-module: seq_shift_out, a loadable PAT_W-bit MSB-first shift register with a bit counter and a last-bit flag.
- The top level holds the FSM, the gap counter, the repeat counter and the abort latch.

Test Plan:
- Defaults; start=1 for 1 cycle with rpt_n=1 -> starting 1 cycle later, p = 1,1,1,1,1,1,1,1,0,0 with p_valid=1 for 10 cycles; last_bit on the 8th; done pulse on cycle 11; busy high cycles 1..11.
- PATTERN=8'hB4, GAP_W=0, rpt_n=3 -> 24 contiguous bits 10110100×3; last_bit at bits 8, 16, 24; one done.
- rpt_n=0 (continuous); abort pulsed during the 2nd bit of repetition 5 -> repetition 5 and its gap complete; FIN follows; no 6th pattern; done once.
- start held high through and after a burst -> a second burst starts on the first IDLE cycle after FIN; start inside a burst does not restart it.
- rst asserted mid-SEND -> all outputs 0 immediately; no done; next start behaves as the first test.
- Loopback to the 8-ones detector with rpt_n=2, GAP_W=0 -> the detector's tick asserts during the second pattern and stays high while the run of 1s continues.
